// File: rtl/im2col_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : im2col_reader_pkg                                         |
// | Brief    : Shared FSM state encodings and default memory map.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package im2col_reader_pkg;

    localparam logic [2:0] STATE_IDLE   = 3'd0;
    localparam logic [2:0] STATE_LOAD   = 3'd1;
    localparam logic [2:0] STATE_WAIT   = 3'd2;
    localparam logic [2:0] STATE_STREAM = 3'd3;
    localparam logic [2:0] STATE_DONE   = 3'd4;

    localparam logic [31:0] MAP_IMG_BASE    = 32'h0000_0000;
    localparam logic [31:0] MAP_WEIGHT_BASE = 32'h0000_1000;
    localparam logic [31:0] MAP_IM2COL_BASE = 32'h0000_2000;
    localparam logic [31:0] MAP_OUTPUT_BASE = 32'h0000_3000;

    // Number of words fetched in one pass: all weights followed by all patch rows.
    function automatic logic [31:0] rd_pass_len(input int unsigned m,
                                                input int unsigned n,
                                                input int unsigned k);
        return 32'(n * k + m * n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/im2col_reader_rd_seq_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : im2col_reader_rd_seq_counter                              |
// | Brief    : Issues the weight/patch read address sequence and tags    |
// |            each returning word with its index one cycle later.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module im2col_reader_rd_seq_counter
    import im2col_reader_pkg::*;
#(
    parameter int unsigned M           = 12,
    parameter int unsigned N           = 9,
    parameter int unsigned K           = 5,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = ADDR_WIDTH'(MAP_IM2COL_BASE),
    parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = ADDR_WIDTH'(MAP_WEIGHT_BASE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  active,
    output logic [ADDR_WIDTH-1:0] addr_rd,
    output logic [31:0]           rd_idx,
    output logic                  rd_vld,
    output logic                  issue_done
);

    localparam logic [31:0] c_NK = 32'(N * K);
    localparam logic [31:0] c_R  = rd_pass_len(M, N, K);

    logic [31:0] r_next_idx;
    logic [31:0] r_pend_idx;
    logic        r_pend_vld;
    logic        w_issue;

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [31:0] idx);
        if (idx < c_NK)
            return WEIGHT_BASE + ADDR_WIDTH'(idx);
        else
            return IM2COL_BASE + ADDR_WIDTH'(idx - c_NK);
    endfunction

    // r_next_idx saturates at R so the sequence never wraps past the last word.
    assign w_issue    = active && (r_next_idx < c_R);
    assign issue_done = (r_next_idx == c_R);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_rd    <= '0;
            r_next_idx <= '0;
            r_pend_idx <= '0;
            r_pend_vld <= 1'b0;
            rd_idx     <= '0;
            rd_vld     <= 1'b0;
        end else begin
            rd_idx <= r_pend_idx;
            rd_vld <= r_pend_vld;
            if (go) begin
                addr_rd    <= addr_of(32'd0);
                r_next_idx <= 32'd1;
                r_pend_idx <= 32'd0;
                r_pend_vld <= 1'b1;
            end else if (w_issue) begin
                addr_rd    <= addr_of(r_next_idx);
                r_next_idx <= r_next_idx + 32'd1;
                r_pend_idx <= r_next_idx;
                r_pend_vld <= 1'b1;
            end else begin
                r_pend_vld <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/im2col_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : im2col_reader                                             |
// | Brief    : Loads weights and im2col patch rows from memory, then     |
// |            streams one patch row per cycle to the systolic array.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module im2col_reader
    import im2col_reader_pkg::*;
#(
    parameter int unsigned M           = 12,
    parameter int unsigned N           = 9,
    parameter int unsigned K           = 5,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = ADDR_WIDTH'(MAP_IM2COL_BASE),
    parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = ADDR_WIDTH'(MAP_WEIGHT_BASE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [ADDR_WIDTH-1:0]     addr_rd,
    input  logic [DATA_WIDTH-1:0]     data_rd,
    output logic [DATA_WIDTH*N*K-1:0] W,
    output logic [DATA_WIDTH*N-1:0]   X,
    output logic                      x_valid,
    output logic                      busy,
    output logic                      done
);

    localparam logic [31:0] c_NK = 32'(N * K);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        w_go;
    logic        w_issue_done;
    logic        w_rd_vld;
    logic [31:0] w_rd_idx;
    logic        w_capture;
    logic        w_is_weight;

    logic [31:0] r_wr_row;
    logic [31:0] r_wr_col;
    logic [31:0] r_rd_row;

    logic [DATA_WIDTH*N*K-1:0] r_w;
    logic [DATA_WIDTH*N-1:0]   r_row_buf [M];

    im2col_reader_rd_seq_counter #(
        .M           (M),
        .N           (N),
        .K           (K),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .IM2COL_BASE (IM2COL_BASE),
        .WEIGHT_BASE (WEIGHT_BASE)
    ) u_rd_seq (
        .clk        (clk),
        .rst        (rst),
        .go         (w_go),
        .active     (r_state == STATE_LOAD),
        .addr_rd    (addr_rd),
        .rd_idx     (w_rd_idx),
        .rd_vld     (w_rd_vld),
        .issue_done (w_issue_done)
    );

    // The last word returns during WAIT, so capture stays open one cycle past LOAD.
    assign w_capture   = w_rd_vld && ((r_state == STATE_LOAD) || (r_state == STATE_WAIT));
    assign w_is_weight = (w_rd_idx < c_NK);
    assign W           = r_w;

    always_ff @(posedge clk) begin
        if (rst) r_state <= STATE_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        x_valid     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        X           = '0;
        case (r_state)
            STATE_IDLE: begin
                if (start) begin
                    w_go        = 1'b1;
                    w_state_nxt = STATE_LOAD;
                end
            end
            STATE_LOAD: begin
                busy = 1'b1;
                if (w_issue_done) w_state_nxt = STATE_WAIT;
            end
            STATE_WAIT: begin
                busy        = 1'b1;
                w_state_nxt = STATE_STREAM;
            end
            STATE_STREAM: begin
                busy    = 1'b1;
                x_valid = 1'b1;
                for (int i = 0; i < int'(M); i++) begin
                    if (r_rd_row == 32'(i)) X = r_row_buf[i];
                end
                if (r_rd_row == 32'(M - 1)) w_state_nxt = STATE_DONE;
            end
            STATE_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_go        = 1'b1;
                    w_state_nxt = STATE_LOAD;
                end
            end
            default: w_state_nxt = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w      <= '0;
            r_wr_row <= '0;
            r_wr_col <= '0;
            r_rd_row <= '0;
        end else begin
            if (w_capture && w_is_weight) begin
                for (int w = 0; w < int'(N * K); w++) begin
                    if (w_rd_idx == 32'(w)) r_w[w*DATA_WIDTH +: DATA_WIDTH] <= data_rd;
                end
            end

            if (w_go) begin
                r_wr_row <= '0;
                r_wr_col <= '0;
            end else if (w_capture && !w_is_weight) begin
                if (r_wr_col == 32'(N - 1)) begin
                    r_wr_col <= '0;
                    r_wr_row <= r_wr_row + 32'd1;
                end else begin
                    r_wr_col <= r_wr_col + 32'd1;
                end
            end

            if ((r_state == STATE_STREAM) && (r_rd_row != 32'(M - 1)))
                r_rd_row <= r_rd_row + 32'd1;
            else
                r_rd_row <= '0;
        end
    end

    // Row buffer holds no reset: it is always fully rewritten before STREAM.
    always_ff @(posedge clk) begin
        if (w_capture && !w_is_weight) begin
            for (int i = 0; i < int'(M); i++) begin
                for (int j = 0; j < int'(N); j++) begin
                    if ((r_wr_row == 32'(i)) && (r_wr_col == 32'(j)))
                        r_row_buf[i][j*DATA_WIDTH +: DATA_WIDTH] <= data_rd;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_im2col_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_im2col_reader                                          |
// | Brief    : Directed self-checking bench for im2col_reader.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_im2col_reader;

    localparam int c_M  = 12;
    localparam int c_N  = 9;
    localparam int c_K  = 5;
    localparam int c_DW = 32;

    logic clk;
    logic rst;
    logic start;
    logic s_start;

    logic [31:0]             addr_rd;
    logic [31:0]             data_rd;
    logic [c_DW*c_N*c_K-1:0] W;
    logic [c_DW*c_N-1:0]     X;
    logic                    x_valid, busy, done;

    logic [31:0] s_addr_rd;
    logic [31:0] s_data_rd;
    logic [31:0] s_W;
    logic [31:0] s_X;
    logic        s_x_valid, s_busy, s_done;

    int tests = 0;
    int fails = 0;

    im2col_reader dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .addr_rd (addr_rd),
        .data_rd (data_rd),
        .W       (W),
        .X       (X),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    im2col_reader #(.M(1), .N(1), .K(1)) dut_s (
        .clk     (clk),
        .rst     (rst),
        .start   (s_start),
        .addr_rd (s_addr_rd),
        .data_rd (s_data_rd),
        .W       (s_W),
        .X       (s_X),
        .x_valid (s_x_valid),
        .busy    (s_busy),
        .done    (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight w holds w+0x100; im2col word (i,j) holds i*N+j.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h1000 && a < 32'h1000 + 32'(c_N * c_K)) return a - 32'h1000 + 32'h100;
        if (a >= 32'h2000 && a < 32'h2000 + 32'(c_M * c_N)) return a - 32'h2000;
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        data_rd   <= mem_word(addr_rd);
        s_data_rd <= mem_word(s_addr_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input int i);
        logic [c_DW*c_N-1:0] e;
        for (int j = 0; j < c_N; j++) e[j*c_DW +: c_DW] = 32'(i * c_N + j);
        tests++;
        assert (X === e) else begin
            fails++;
            $error("FAIL x_row%0d: observed %h expected %h", i, X, e);
        end
    endtask

    task automatic chk_w();
        logic [c_DW*c_N*c_K-1:0] e;
        for (int w = 0; w < c_N * c_K; w++) e[w*c_DW +: c_DW] = 32'(w + 32'h100);
        chk("w_word0", 64'(W[31:0]), 64'h100);
        chk("w_word44", 64'(W[44*c_DW +: c_DW]), 64'h12C);
        tests++;
        assert (W === e) else begin
            fails++;
            $error("FAIL w_all: observed %h expected %h", W, e);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_addr", 64'(addr_rd), 0);
        chk("rst_W", 64'(|W), 0);
        chk("rst_X", 64'(|X), 0);
        chk("rst_xvalid", 64'(x_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
    endtask

    // mode 0: single pulse, 1: extra pulses while busy, 2: start held high.
    // rst_at != 0 asserts rst in that cycle and checks reset values one cycle later.
    task automatic run_pass(input int mode, input int rst_at);
        start = 1'b1;
        for (int c = 1; c <= 167; c++) begin
            tick();
            if (rst_at != 0 && c == rst_at + 1) begin
                chk_reset_vals();
                rst = 1'b0;
                return;
            end
            start = (mode == 2) || (mode == 1 && (c == 20 || c == 160));
            if (rst_at != 0 && c == rst_at) rst = 1'b1;
            chk($sformatf("x_valid_c%0d", c), 64'(x_valid), 64'(c >= 155 && c <= 166));
            chk($sformatf("busy_c%0d", c), 64'(busy), 64'(c <= 166));
            chk($sformatf("done_c%0d", c), 64'(done), 64'(c == 167));
            if (c == 1)   chk("addr_c1", 64'(addr_rd), 64'h1000);
            if (c == 45)  chk("addr_c45", 64'(addr_rd), 64'h102C);
            if (c == 46)  chk("addr_c46", 64'(addr_rd), 64'h2000);
            if (c == 153) chk("addr_c153", 64'(addr_rd), 64'h206B);
            if (c == 154) chk("addr_c154", 64'(addr_rd), 64'h206B);
            if (c >= 155 && c <= 166) chk_row(c - 155);
            else chk($sformatf("x_zero_c%0d", c), 64'(|X), 0);
            if (c == 167) chk_w();
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_vals();
        chk("s_rst_addr", 64'(s_addr_rd), 0);
        chk("s_rst_done", 64'(s_done), 0);

        // Degenerate M=N=K=1 pass: R=2.
        s_start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            s_start = 1'b0;
            chk($sformatf("s_xvalid_c%0d", c), 64'(s_x_valid), 64'(c == 4));
            chk($sformatf("s_done_c%0d", c), 64'(s_done), 64'(c >= 5));
            chk($sformatf("s_busy_c%0d", c), 64'(s_busy), 64'(c <= 4));
            if (c == 1) chk("s_addr_c1", 64'(s_addr_rd), 64'h1000);
            if (c == 2) chk("s_addr_c2", 64'(s_addr_rd), 64'h2000);
            if (c == 3) chk("s_addr_c3", 64'(s_addr_rd), 64'h2000);
            if (c == 5) chk("s_W", 64'(s_W), 64'h100);
            if (c == 5) chk("s_X_done", 64'(s_X), 0);
        end

        run_pass(0, 0);     // basic pass and W packing
        run_pass(1, 0);     // starts while busy are ignored
        run_pass(2, 0);     // held start: pass A
        run_pass(2, 0);     // held start: pass B begins in done cycle
        start = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        run_pass(0, 158);   // reset mid-stream
        run_pass(0, 0);     // fresh pass reproduces basic timing

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
